// File: rtl/vga_pkg.sv
// Shared types, default 800x600@72 timing and pixel helpers for the VGA scan-out.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package vga_pkg;

    typedef enum logic [1:0] {
        M8_DIRECT = 2'd0,
        M4_PAL    = 2'd1,
        M2_PAL    = 2'd2,
        M1_PAL    = 2'd3
    } mode_e;

    // Default 800x600@72 (50 MHz pixel clock) timing
    localparam int DEF_H_VIS  = 800;
    localparam int DEF_H_FP   = 56;
    localparam int DEF_H_SYNC = 120;
    localparam int DEF_H_BP   = 64;
    localparam int DEF_V_VIS  = 600;
    localparam int DEF_V_FP   = 37;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 23;

    // Per-pixel sideband carried alongside the RAM read
    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic       frm;
        mode_e      mode;
        logic [2:0] idx;
    } pipe_t;

    // RRRGGGBB to 4:4:4, replicating MSBs so full scale maps to 0xF
    function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    // log2(pixels per byte): 0 for 8bpp up to 3 for 1bpp
    function automatic logic [1:0] pix_shift(input mode_e m);
        return m;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with visible flag and raw (active-high) sync.
// Latency: outputs are the current counter state, no extra delay.
// Backpressure: none; free-running on every pixel clock.
//
// Ports: clock, reset_n; h/v counters; vis = inside visible area;
// hs_act/vs_act = inside the sync pulse, before polarity is applied.
module vga_timing #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23,
    parameter int HW     = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
    parameter int VW     = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          vis,
    output logic          hs_act,
    output logic          vs_act
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // Compare in 32 bits so sync end points equal to the total never overflow
    assign vis    = (32'(h) < H_VIS) && (32'(v) < V_VIS);
    assign hs_act = (32'(h) >= H_VIS + H_FP) && (32'(h) < H_VIS + H_FP + H_SYNC);
    assign vs_act = (32'(v) >= V_VIS + V_FP) && (32'(v) < V_VIS + V_FP + V_SYNC);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: raster timing, byte-wide video RAM fetch, 8/4/2/1 bpp decode, palette, RGB444 + sync.
// Latency: address one clock after the counter cycle; RGB/HS/VS/frame RD_LAT+2 clocks after it.
// Backpressure: none; RAM must return data exactly RD_LAT clocks after address.
//
// Ports: clock, reset_n; mode/double (sampled at frame origin); pal_we/pal_idx/pal_rgb
// palette write port; address/data video RAM read port; R,G,B,HS,VS pins; frame pulse.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int HS_POL = 1,
    parameter int VS_POL = 1,
    parameter int AW     = 18,
    parameter int RD_LAT = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    mode,
    input  logic          double,
    input  logic          pal_we,
    input  logic [3:0]    pal_idx,
    input  logic [11:0]   pal_rgb,
    output logic [AW-1:0] address,
    input  logic [7:0]    data,
    output logic [3:0]    R,
    output logic [3:0]    G,
    output logic [3:0]    B,
    output logic          HS,
    output logic          VS,
    output logic          frame
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [AW-1:0] H_VIS_A = AW'(H_VIS);
    localparam logic          HS_ON   = 1'(HS_POL);
    localparam logic          VS_ON   = 1'(VS_POL);

    // ---------------------------------------------------------------- timing
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          vis, hs_act, vs_act;

    vga_timing #(
        .H_VIS (H_VIS),  .H_FP  (H_FP),  .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS (V_VIS),  .V_FP  (V_FP),  .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW    (HW),     .VW    (VW)
    ) u_timing (
        .clock  (clock),
        .reset_n(reset_n),
        .h      (h),
        .v      (v),
        .vis    (vis),
        .hs_act (hs_act),
        .vs_act (vs_act)
    );

    // ----------------------------------------------------- mode shadowing
    // At the origin the live inputs are used directly, so the whole frame
    // (including pixel 0,0) renders in the newly latched format.
    mode_e mode_q;
    logic  dbl_q;
    logic  at_origin;
    mode_e mode_cur;
    logic  dbl_cur;

    assign at_origin = (h == '0) && (v == '0);
    assign mode_cur  = at_origin ? mode_e'(mode) : mode_q;
    assign dbl_cur   = at_origin ? double : dbl_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= M8_DIRECT;
            dbl_q  <= 1'b0;
        end else if (at_origin) begin
            mode_q <= mode_e'(mode);
            dbl_q  <= double;
        end
    end

    // ----------------------------------------------------- address generation
    logic [1:0]    s_cur;
    logic [HW-1:0] xe;
    logic [HW-1:0] xoff;
    logic [AW-1:0] stride;
    logic [AW-1:0] line_base;
    logic [AW-1:0] fetch_addr;
    logic          line_vis;
    logic          line_adv;

    assign s_cur      = pix_shift(mode_cur);
    assign xe         = dbl_cur ? (h >> 1) : h;
    assign xoff       = xe >> s_cur;
    assign stride     = (H_VIS_A >> dbl_cur) >> s_cur;
    assign fetch_addr = line_base + AW'(xoff);
    assign line_vis   = 32'(v) < V_VIS;
    // With doubling each source line is shown twice: advance after odd lines only
    assign line_adv   = line_vis && (!dbl_cur || v[0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_base <= '0;
        end else if (h == H_LAST) begin
            if (v == V_LAST)
                line_base <= '0;
            else if (line_adv)
                line_base <= line_base + stride;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            address <= '0;
        else
            address <= vis ? fetch_addr : '0;
    end

    // ----------------------------------------------------- sideband delay line
    // pipe[k] holds the sideband for the counter cycle k+1 clocks ago;
    // pipe[RD_LAT] lines up with the RAM data presented this cycle.
    pipe_t pipe_in;
    pipe_t pipe [RD_LAT+1];

    assign pipe_in.vis  = vis;
    assign pipe_in.hs   = hs_act;
    assign pipe_in.vs   = vs_act;
    assign pipe_in.frm  = (h == '0) && (32'(v) == V_VIS);
    assign pipe_in.mode = mode_cur;
    assign pipe_in.idx  = xe[2:0] & ((3'b001 << s_cur) - 3'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= RD_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= pipe_in;
            for (int i = 1; i <= RD_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    // ----------------------------------------------------- palette
    logic [11:0] pal [16];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++)
                pal[i] <= {4'(i), 4'(i), 4'(i)};
        end else if (pal_we) begin
            pal[pal_idx] <= pal_rgb;
        end
    end

    // ----------------------------------------------------- colour stage
    pipe_t       cs;
    logic [1:0]  s_cs;
    logic [2:0]  shamt;
    logic [7:0]  shifted;
    logic [3:0]  pidx;
    logic [11:0] rgb_nxt;

    assign cs   = pipe[RD_LAT];
    assign s_cs = pix_shift(cs.mode);

    always_comb begin
        // Move the selected MSB-first field to the top of the byte
        shamt   = cs.idx << (2'd3 - s_cs);
        shifted = data << shamt;
        pidx    = 4'd0;
        rgb_nxt = 12'd0;
        case (cs.mode)
            M4_PAL:  pidx = shifted[7:4];
            M2_PAL:  pidx = {2'b00, shifted[7:6]};
            default: pidx = {3'b000, shifted[7]};
        endcase
        if (cs.vis)
            rgb_nxt = (cs.mode == M8_DIRECT) ? rgb332_to_444(data) : pal[pidx];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            R     <= '0;
            G     <= '0;
            B     <= '0;
            HS    <= ~HS_ON;
            VS    <= ~VS_ON;
            frame <= 1'b0;
        end else begin
            R     <= rgb_nxt[11:8];
            G     <= rgb_nxt[7:4];
            B     <= rgb_nxt[3:0];
            HS    <= cs.hs ^ ~HS_ON;
            VS    <= cs.vs ^ ~VS_ON;
            frame <= cs.frm;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced 32x6 raster (40x10 total).
// Latency: expectations are keyed by clock count; address at t+1, pixels/sync at t+RD_LAT+2.
// Backpressure: none; a bench RAM model answers reads with RD_LAT clocks of latency.
module tb_vga_scanout;

    localparam int H_VIS = 32, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_VIS = 6,  V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int AW = 10, RD_LAT = 2;
    localparam int H_TOT = 40, FRM = 400, LAT = RD_LAT + 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [1:0]    mode;
    logic          double;
    logic          pal_we;
    logic [3:0]    pal_idx;
    logic [11:0]   pal_rgb;
    logic [AW-1:0] address;
    logic [7:0]    data;
    logic [3:0]    R, G, B;
    logic          HS, VS, frame;

    always #5 clock = ~clock;

    vga_scanout #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1), .VS_POL(1), .AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .mode   (mode),
        .double (double),
        .pal_we (pal_we),
        .pal_idx(pal_idx),
        .pal_rgb(pal_rgb),
        .address(address),
        .data   (data),
        .R      (R),
        .G      (G),
        .B      (B),
        .HS     (HS),
        .VS     (VS),
        .frame  (frame)
    );

    // Video RAM model with RD_LAT clocks from address to data
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rd_pipe [RD_LAT];

    always @(posedge clock) begin
        rd_pipe[0] <= mem[address];
        for (int i = 1; i < RD_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign data = rd_pipe[RD_LAT-1];

    // Clocks since reset release; counter cycle t is visible while cyc == t
    int cyc;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string kname [5] = '{"rgb", "addr", "hs", "vs", "frame"};

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic int pos(input int f, input int vv, input int hh);
        return f * FRM + vv * H_TOT + hh;
    endfunction

    task automatic push(input int c, input int k, input int val);
        exp_t e;
        e.cyc = c; e.kind = k; e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_pix(input int t, input int rgb);  push(t + LAT, 0, rgb); endtask
    task automatic exp_addr(input int t, input int a);   push(t + 1,   1, a);   endtask
    task automatic exp_hs(input int t, input int val);   push(t + LAT, 2, val); endtask
    task automatic exp_vs(input int t, input int val);   push(t + LAT, 3, val); endtask
    task automatic exp_frm(input int t, input int val);  push(t + LAT, 4, val); endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Monitor: compare every expectation due on this clock
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    int act;
                    case (sb[i].kind)
                        0:       act = int'({R, G, B});
                        1:       act = int'(address);
                        2:       act = int'(HS);
                        3:       act = int'(VS);
                        default: act = int'(frame);
                    endcase
                    check($sformatf("%s@cyc%0d", kname[sb[i].kind], cyc), act, sb[i].val);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        mode    = 2'd0;
        double  = 1'b0;
        pal_we  = 1'b0;
        pal_idx = 4'd0;
        pal_rgb = 12'd0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[0]   = 8'hE3;
        mem[1]   = 8'h1C;
        mem[8]   = 8'h1B;
        mem[16]  = 8'h5A;
        mem[32]  = 8'h03;
        mem[48]  = 8'h5A;
        mem[133] = 8'hE0;

        repeat (3) @(negedge clock);
        check("rst_rgb",   int'({R, G, B}), 0);
        check("rst_hs",    int'(HS), 0);
        check("rst_vs",    int'(VS), 0);
        check("rst_addr",  int'(address), 0);
        check("rst_frame", int'(frame), 0);
        reset_n = 1'b1;

        // Frame 0: 8bpp direct, stride 32
        exp_addr(pos(0,0,0), 0);     exp_pix(pos(0,0,0), 'hF0F);
        exp_pix(pos(0,0,1), 'h0F0);
        exp_addr(pos(0,1,0), 32);    exp_pix(pos(0,1,0), 'h00F);
        exp_addr(pos(0,0,33), 0);    exp_pix(pos(0,0,33), 'h000);
        exp_hs(pos(0,0,33), 0);      exp_hs(pos(0,0,34), 1);
        exp_hs(pos(0,0,36), 1);      exp_hs(pos(0,0,37), 0);
        exp_vs(pos(0,6,39), 0);      exp_vs(pos(0,7,0), 1);
        exp_vs(pos(0,8,39), 1);      exp_vs(pos(0,9,0), 0);
        exp_frm(pos(0,5,39), 0);     exp_frm(pos(0,6,0), 1);
        exp_frm(pos(0,6,1), 0);      exp_frm(pos(1,6,0), 1);
        exp_addr(pos(0,4,5), 133);   exp_pix(pos(0,4,5), 'hF00);
        // Frame 1: 4bpp palette, stride 16; entry 5 rewritten on line 2
        exp_addr(pos(1,1,0), 16);    exp_addr(pos(1,1,1), 16);
        exp_pix(pos(1,1,0), 'h555);  exp_pix(pos(1,1,1), 'hAAA);
        exp_addr(pos(1,3,0), 48);
        exp_pix(pos(1,3,0), 'hF00);  exp_pix(pos(1,3,1), 'hAAA);
        // Frame 2: 1bpp doubled, stride 2, address steps every 16 clocks
        exp_addr(pos(2,0,15), 0);    exp_addr(pos(2,0,16), 1);
        exp_addr(pos(2,1,0), 0);     exp_addr(pos(2,1,16), 1);
        exp_addr(pos(2,2,0), 2);     exp_addr(pos(2,5,16), 5);
        exp_pix(pos(2,0,0), 'h111);  exp_pix(pos(2,0,7), 'h000);
        exp_pix(pos(2,0,12), 'h111);
        // Frame 3: 8bpp even after mid-frame switch request; frame 4: 2bpp, stride 8
        exp_addr(pos(3,4,5), 133);   exp_pix(pos(3,4,5), 'hF00);
        exp_addr(pos(4,1,0), 8);     exp_addr(pos(4,1,4), 9);
        exp_pix(pos(4,1,2), 'h222);  exp_pix(pos(4,1,3), 'h333);
        exp_addr(pos(4,2,0), 16);

        wait_cyc(pos(0,3,0));  mode = 2'd1;
        wait_cyc(pos(1,2,10));
        pal_we = 1'b1; pal_idx = 4'd5; pal_rgb = 12'hF00;
        @(negedge clock);
        pal_we = 1'b0;
        wait_cyc(pos(1,5,0));  mode = 2'd3; double = 1'b1;
        wait_cyc(pos(2,4,0));  mode = 2'd0; double = 1'b0;
        wait_cyc(pos(3,3,0));  mode = 2'd2;
        wait_cyc(pos(5,2,10));

        // Asynchronous reset in the middle of a visible line
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_rgb",   int'({R, G, B}), 0);
        check("mid_rst_hs",    int'(HS), 0);
        check("mid_rst_vs",    int'(VS), 0);
        check("mid_rst_addr",  int'(address), 0);
        check("mid_rst_frame", int'(frame), 0);
        mode   = 2'd1;
        double = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Restart: 4bpp from the very first pixel, palette back to grey ramp
        exp_pix(pos(0,0,0), 'hEEE);  exp_pix(pos(0,0,1), 'h333);
        exp_hs(pos(0,0,33), 0);      exp_hs(pos(0,0,34), 1);
        exp_addr(pos(0,1,0), 16);    exp_pix(pos(0,1,0), 'h555);
        wait_cyc(60);

        foreach (sb[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s@cyc%0d: never reached, expected %0h",
                     kname[sb[i].kind], sb[i].cyc, sb[i].val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
